// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch button path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESS   = 2'd2,
    LONG    = 2'd3
  } state_t;

  // Defaults assume a 100 MHz clock: 0.5 s long-press, 0.1 s repeat period.
  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// Converts a debounced button level into one-cycle press/release/short/long/
// repeat strobes plus a registered held flag.
module button_event
  import stopwatch_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Single FSM: state, counter and all registered outputs; release wins over thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOCKOUT;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        LOCKOUT: begin
          // Button may already be down at reset; stay silent until it is seen low.
          if (!level) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        IDLE: begin
          if (level) begin
            state       <= PRESS;
            cnt         <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end
        end
        PRESS: begin
          if (!level) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            held          <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!level) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOCKOUT;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
